// File: rtl/md5_padder.sv
// MD5 message padder: collects a byte stream into 512-bit blocks, appends the
// 0x80 terminator and the 64-bit little-endian bit length, and hands blocks downstream.
module md5_padder #(
  parameter int CNT_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_last,
  output logic         byte_ready,
  input  logic         empty_msg,
  output logic [511:0] part_out,
  output logic         part_valid,
  input  logic         part_ready,
  output logic         part_last,
  output logic [63:0]  total_data_length
);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

  state_t             state_q, state_d;
  logic [511:0]       buf_q, buf_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               extra_q, extra_d;
  logic               pad0_q, pad0_d;
  logic [5:0]         idx_inc;
  logic [CNT_W-1:0]   cnt_inc;

  // Bit length is the byte count shifted by three, truncated to 64 bits.
  function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
    logic [CNT_W+66:0] wide;
    wide = {64'd0, c, 3'b000};
    return wide[63:0];
  endfunction

  assign idx_inc = idx_q + 6'd1;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      pad0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      pad0_q  <= pad0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    extra_d = extra_q;
    pad0_d  = pad0_q;
    case (state_q)
      FILL: begin
        if (byte_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = byte_in;
          idx_d = idx_inc;
          cnt_d = cnt_inc;
          if (byte_last) begin
            state_d = EMIT;
            if (idx_q <= 6'd54) begin
              buf_d[{idx_inc, 3'b000} +: 8] = 8'h80;
              buf_d[511:448] = bit_len(cnt_inc);
              last_d = 1'b1;
            end else if (idx_q != 6'd63) begin
              // No room for the length: terminator here, length in a trailing block.
              buf_d[{idx_inc, 3'b000} +: 8] = 8'h80;
              extra_d = 1'b1;
              pad0_d  = 1'b0;
            end else begin
              extra_d = 1'b1;
              pad0_d  = 1'b1;
            end
          end else if (idx_q == 6'd63) begin
            state_d = EMIT;
          end
        end else if (empty_msg && (cnt_q == '0)) begin
          buf_d[7:0] = 8'h80;
          last_d  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (part_ready) begin
          buf_d = '0;
          if (last_q) begin
            state_d = FILL;
            cnt_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
          end else if (extra_q) begin
            state_d = EXTRA;
          end else begin
            state_d = FILL;
          end
        end
      end
      EXTRA: begin
        buf_d[511:448] = bit_len(cnt_q);
        if (pad0_q) buf_d[7:0] = 8'h80;
        last_d  = 1'b1;
        extra_d = 1'b0;
        pad0_d  = 1'b0;
        state_d = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    byte_ready        = (state_q == FILL);
    part_valid        = (state_q == EMIT);
    part_last         = (state_q == EMIT) && last_q;
    part_out          = buf_q;
    total_data_length = bit_len(cnt_q);
  end

endmodule

// File: tb/tb_md5_padder.sv
// Scoreboard bench for md5_padder: directed messages push hand-computed blocks,
// a monitor pops and compares every block handshake.
module tb_md5_padder;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic         byte_last;
   logic         byte_ready;
   logic         empty_msg;
   logic [511:0] part_out;
   logic         part_valid;
   logic         part_ready;
   logic         part_last;
   logic [63:0]  total_data_length;

   typedef struct packed {
      logic [511:0] data;
      logic         last;
      logic [63:0]  len;
   } exp_t;

   exp_t         expQ[$];
   int           total = 0;
   int           bad = 0;
   logic         holdEmpty = 1'b0;
   logic [7:0]   msgBuf [0:127];
   logic [511:0] snap;
   logic [511:0] blk;

   md5_padder dut (
      .clk(clk),
      .reset(reset),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .byte_last(byte_last),
      .byte_ready(byte_ready),
      .empty_msg(empty_msg),
      .part_out(part_out),
      .part_valid(part_valid),
      .part_ready(part_ready),
      .part_last(part_last),
      .total_data_length(total_data_length)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic failNow(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got timeout want completion", name);
   endtask

   function automatic logic [511:0] fillBytes(input int n, input logic [7:0] v);
      logic [511:0] b;
      b = '0;
      for (int i = 0; i < n; i++) b[i*8 +: 8] = v;
      return b;
   endfunction

   function automatic logic [511:0] setByte(input logic [511:0] b, input int i, input logic [7:0] v);
      logic [511:0] r;
      r = b;
      r[i*8 +: 8] = v;
      return r;
   endfunction

   task automatic pushBlock(input logic [511:0] d, input logic l, input logic [63:0] len);
      exp_t e;
      e.data = d;
      e.last = l;
      e.len  = len;
      expQ.push_back(e);
   endtask

   task automatic loadRepeat(input int n, input logic [7:0] v);
      for (int i = 0; i < n; i++) msgBuf[i] = v;
   endtask

   // Drive n bytes from msgBuf, waiting out backpressure; endMsg flags the final byte.
   task automatic applyStimulus(input int n, input bit endMsg);
      int guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         byte_in    = msgBuf[i];
         byte_valid = 1'b1;
         byte_last  = endMsg && (i == n - 1);
         empty_msg  = holdEmpty;
         guard = 0;
         while (!byte_ready && guard < 500) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 500) begin
            failNow("byte_ready_wait");
            byte_valid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      #1;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      empty_msg  = 1'b0;
   endtask

   task automatic waitDrain();
      int g;
      g = 0;
      while (expQ.size() != 0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending blocks want 0", expQ.size());
      end
   endtask

   // Monitor: every block handshake is matched against the oldest expected block.
   always @(negedge clk) begin
      if (reset && part_valid && part_ready) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_block: got %0h want none", part_out);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("block_data", part_out, e.data);
            checkOutput("block_last", {511'd0, part_last}, {511'd0, e.last});
            if (e.last) checkOutput("bit_length", {448'd0, total_data_length}, {448'd0, e.len});
         end
      end
   end

   initial begin
      reset      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      empty_msg  = 1'b0;
      part_ready = 1'b1;
      #1;
      checkOutput("rst_part_valid", {511'd0, part_valid}, 512'd0);
      checkOutput("rst_byte_ready", {511'd0, byte_ready}, 512'd1);
      checkOutput("rst_part_out", part_out, 512'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      $display("[TB] empty message");
      pushBlock(setByte(512'd0, 0, 8'h80), 1'b1, 64'd0);
      @(negedge clk);
      empty_msg = 1'b1;
      @(posedge clk);
      #1;
      empty_msg = 1'b0;
      waitDrain();

      $display("[TB] abc");
      msgBuf[0] = 8'h61; msgBuf[1] = 8'h62; msgBuf[2] = 8'h63;
      blk = 512'd0;
      blk = setByte(blk, 0, 8'h61); blk = setByte(blk, 1, 8'h62);
      blk = setByte(blk, 2, 8'h63); blk = setByte(blk, 3, 8'h80);
      blk = setByte(blk, 56, 8'h18);
      pushBlock(blk, 1'b1, 64'd24);
      applyStimulus(3, 1'b1);
      waitDrain();

      $display("[TB] 55 bytes");
      loadRepeat(55, 8'h61);
      blk = fillBytes(55, 8'h61);
      blk = setByte(blk, 55, 8'h80); blk = setByte(blk, 56, 8'hB8); blk = setByte(blk, 57, 8'h01);
      pushBlock(blk, 1'b1, 64'd440);
      applyStimulus(55, 1'b1);
      waitDrain();

      $display("[TB] 64 bytes");
      loadRepeat(64, 8'h61);
      pushBlock(fillBytes(64, 8'h61), 1'b0, 64'd0);
      blk = setByte(512'd0, 0, 8'h80);
      blk = setByte(blk, 57, 8'h02);
      pushBlock(blk, 1'b1, 64'd512);
      applyStimulus(64, 1'b1);
      waitDrain();

      $display("[TB] 70 bytes");
      loadRepeat(70, 8'h61);
      pushBlock(fillBytes(64, 8'h61), 1'b0, 64'd0);
      blk = fillBytes(6, 8'h61);
      blk = setByte(blk, 6, 8'h80); blk = setByte(blk, 56, 8'h30); blk = setByte(blk, 57, 8'h02);
      pushBlock(blk, 1'b1, 64'd560);
      applyStimulus(70, 1'b1);
      waitDrain();

      $display("[TB] 56 bytes under backpressure");
      @(posedge clk);
      #1;
      part_ready = 1'b0;
      loadRepeat(56, 8'h61);
      pushBlock(setByte(fillBytes(56, 8'h61), 56, 8'h80), 1'b0, 64'd0);
      blk = setByte(512'd0, 56, 8'hC0);
      blk = setByte(blk, 57, 8'h01);
      pushBlock(blk, 1'b1, 64'd448);
      applyStimulus(56, 1'b1);
      @(negedge clk);
      checkOutput("bp_valid_rise", {511'd0, part_valid}, 512'd1);
      snap = part_out;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("bp_hold_data", part_out, snap);
         checkOutput("bp_byte_ready", {511'd0, byte_ready}, 512'd0);
      end
      @(posedge clk);
      #1;
      part_ready = 1'b1;
      waitDrain();

      $display("[TB] reset mid-message");
      loadRepeat(30, 8'h5A);
      applyStimulus(30, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_part_out", part_out, 512'd0);
      checkOutput("mid_rst_part_valid", {511'd0, part_valid}, 512'd0);
      checkOutput("mid_rst_part_last", {511'd0, part_last}, 512'd0);
      checkOutput("mid_rst_length", {448'd0, total_data_length}, 512'd0);
      checkOutput("mid_rst_byte_ready", {511'd0, byte_ready}, 512'd1);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] abc after reset with empty_msg held high");
      msgBuf[0] = 8'h61; msgBuf[1] = 8'h62; msgBuf[2] = 8'h63;
      blk = 512'd0;
      blk = setByte(blk, 0, 8'h61); blk = setByte(blk, 1, 8'h62);
      blk = setByte(blk, 2, 8'h63); blk = setByte(blk, 3, 8'h80);
      blk = setByte(blk, 56, 8'h18);
      pushBlock(blk, 1'b1, 64'd24);
      holdEmpty = 1'b1;
      applyStimulus(3, 1'b1);
      holdEmpty = 1'b0;
      waitDrain();

      repeat (5) @(negedge clk);
      checkOutput("idle_no_valid", {511'd0, part_valid}, 512'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
